// File: rtl/bk_pkg.sv
// -----------------------------------------------------------------------------
// bk_pkg
// Shared types and elaboration-time helpers for the pipelined Brent-Kung
// adder (brent_kung_pipe_adder) and its prefix-level sub-module.
//   gp_t          : one (generate, propagate) column pair.
//   bk_levels     : number of prefix levels after level 0, 2*log2(WIDTH)-1.
//   bk_reg_after  : 1 when a pipeline register follows the given level
//                   (the caller also excludes the final level).
//   bk_latency    : input-accept to out_valid latency in clock cycles.
// -----------------------------------------------------------------------------
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int bk_levels(input int width);
        return 2 * $clog2(width) - 1;
    endfunction

    function automatic bit bk_reg_after(input int level, input int reg_every);
        if (reg_every <= 0 || level <= 0) begin
            return 1'b0;
        end
        return (level % reg_every) == 0;
    endfunction

    function automatic int bk_latency(input int width, input int reg_every);
        int levels;
        levels = bk_levels(width);
        if (reg_every <= 0) begin
            return 2;
        end
        // Input register + one register per internal cut + output register.
        return (levels + reg_every - 1) / reg_every + 1;
    endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// -----------------------------------------------------------------------------
// bk_prefix_level
// One combinational level of the Brent-Kung prefix network.
//   LEVEL 1..log2(WIDTH)              : up-sweep, black cells at distance
//                                       2^(LEVEL-1) on columns i where
//                                       (i+1) is a multiple of 2^LEVEL.
//   LEVEL log2(WIDTH)+1..2*log2(W)-1  : down-sweep, gray cells filling the
//                                       remaining columns from the nearest
//                                       finished column DIST below.
// Ports:
//   gp_in  [WIDTH] : group (g,p) per column entering this level.
//   gp_out [WIDTH] : group (g,p) per column leaving this level.
// -----------------------------------------------------------------------------
module bk_prefix_level
    import bk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 1
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    localparam int LOG  = $clog2(WIDTH);
    localparam bit UP   = (LEVEL <= LOG);
    localparam int DIST = UP ? (1 << (LEVEL - 1)) : (1 << (2 * LOG - 1 - LEVEL));

    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        localparam bit ACTIVE = UP ? (((i + 1) % (2 * DIST)) == 0)
                                   : ((((i + 1) % (2 * DIST)) == DIST) && (i >= 2 * DIST));
        if (ACTIVE && UP) begin : g_black
            assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-DIST].g);
            assign gp_out[i].p = gp_in[i].p & gp_in[i-DIST].p;
        end else if (ACTIVE) begin : g_gray
            // The column below is already a full prefix from bit 0, so only
            // g is needed; p is carried unchanged and never read downstream.
            assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[i-DIST].g);
            assign gp_out[i].p = gp_in[i].p;
        end else begin : g_pass
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/brent_kung_pipe_adder.sv
// -----------------------------------------------------------------------------
// brent_kung_pipe_adder
// Pipelined Brent-Kung prefix adder/subtractor with carry-in.
//   result = a + (sub ? ~b : b) + (cin ^ sub)   (modulo 2^WIDTH)
// In subtract mode cout=1 means no borrow.
//
// Parameters:
//   WIDTH     : operand width, power of two, 4..128.
//   REG_EVERY : prefix levels between internal registers, 0 = none.
// Optional build macro:
//   BK_SIGNED_OVF_EN : adds output ovf (two's-complement signed overflow),
//                      registered alongside sum.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset.
//   in_valid / in_ready : operand beat handshake.
//   a, b, cin, sub      : operands, carry-in, subtract select.
//   out_valid/out_ready : result beat handshake.
//   sum, cout [, ovf]   : result, carry out of MSB [, signed overflow].
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// 1. The whole pipe advances together when advance = !out_valid | out_ready;
// in_ready equals advance, so input and output may transfer in the same cycle
// (1 beat/cycle). While out_valid=1 and out_ready=0 every stage holds and the
// outputs stay stable. Bubbles move with the pipe and are overwritten.
// -----------------------------------------------------------------------------
module brent_kung_pipe_adder
    import bk_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef BK_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int LEVELS = bk_levels(WIDTH);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Input register: operand B and carry-in are already conditioned for
    // subtraction, so the network only ever adds.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic             v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else if (advance) begin
            a_q <= a;
            b_q <= b ^ {WIDTH{sub}};
            c_q <= cin ^ sub;
            v_q <= in_valid;
        end
    end

    // Level 0: per-bit g/p, with the carry-in folded into column 0 so every
    // later group generate already includes it.
    gp_t [WIDTH-1:0] gp0;
    logic [WIDTH-1:0] p0;

    assign p0 = a_q ^ b_q;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gp0[i].g = a_q[i] & b_q[i];
            gp0[i].p = p0[i];
        end
        gp0[0].g = (a_q[0] & b_q[0]) | (p0[0] & c_q);
    end

    // Stage j holds the network state after level j. A register follows
    // level j when bk_reg_after says so and j is not the last level (the
    // output register plays that role). Level-0 p, c_eff and the valid bit
    // travel alongside so the sum can be formed at the end.
    for (genvar j = 0; j <= LEVELS; j++) begin : g_lvl
        gp_t [WIDTH-1:0]  gp_s;
        logic [WIDTH-1:0] p0_s;
        logic             c0_s;
        logic             v_s;

        if (j == 0) begin : g_src
            assign gp_s = gp0;
            assign p0_s = p0;
            assign c0_s = c_q;
            assign v_s  = v_q;
        end else begin : g_net
            gp_t [WIDTH-1:0] gp_c;

            bk_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (j)
            ) u_level (
                .gp_in  (g_lvl[j-1].gp_s),
                .gp_out (gp_c)
            );

            if (bk_reg_after(j, REG_EVERY) && (j < LEVELS)) begin : g_reg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        gp_s <= '0;
                        p0_s <= '0;
                        c0_s <= 1'b0;
                        v_s  <= 1'b0;
                    end else if (advance) begin
                        gp_s <= gp_c;
                        p0_s <= g_lvl[j-1].p0_s;
                        c0_s <= g_lvl[j-1].c0_s;
                        v_s  <= g_lvl[j-1].v_s;
                    end
                end
            end else begin : g_thru
                assign gp_s = gp_c;
                assign p0_s = g_lvl[j-1].p0_s;
                assign c0_s = g_lvl[j-1].c0_s;
                assign v_s  = g_lvl[j-1].v_s;
            end
        end
    end

    // Sum formation: c[0] is the raw c_eff, c[i] is the prefix generate of
    // bits i-1..0 (which already contains c_eff).
    gp_t [WIDTH-1:0]  gp_last;
    logic [WIDTH-1:0] g_last;
    logic [WIDTH-1:0] unused_p_last;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign gp_last = g_lvl[LEVELS].gp_s;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            g_last[i]        = gp_last[i].g;
            unused_p_last[i] = gp_last[i].p;
        end
    end

    assign carry  = {g_last[WIDTH-2:0], g_lvl[LEVELS].c0_s};
    assign sum_d  = g_lvl[LEVELS].p0_s ^ carry;
    assign cout_d = g_last[WIDTH-1];

`ifdef BK_SIGNED_OVF_EN
    logic ovf_d;
    assign ovf_d = carry[WIDTH-1] ^ cout_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef BK_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (advance) begin
            out_valid <= g_lvl[LEVELS].v_s;
            sum       <= sum_d;
            cout      <= cout_d;
`ifdef BK_SIGNED_OVF_EN
            ovf       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_brent_kung_pipe_adder
// Bench for brent_kung_pipe_adder: a 32-bit/REG_EVERY=3 instance (latency 4)
// and an 8-bit/REG_EVERY=0 instance (latency 2). Results are checked against
// expected {cout,sum} queues filled when each beat is accepted.
// With BK_SIGNED_OVF_EN defined the ovf outputs are connected and checked.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_brent_kung_pipe_adder;

    localparam int LAT32 = 4;
    localparam int LAT8  = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- 32-bit DUT ----------------
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;
`ifdef BK_SIGNED_OVF_EN
    logic        ovf;
`endif

    brent_kung_pipe_adder #(.WIDTH(32), .REG_EVERY(3)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef BK_SIGNED_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    // ---------------- 8-bit DUT, no internal registers ----------------
    logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;
`ifdef BK_SIGNED_OVF_EN
    logic       ovf8;
`endif

    brent_kung_pipe_adder #(.WIDTH(8), .REG_EVERY(0)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
`ifdef BK_SIGNED_OVF_EN
        .ovf       (ovf8),
`endif
        .cout      (cout8)
    );

    // ---------------- scoreboard ----------------
    int          n_vec;
    int          n_bad;
    logic [32:0] exp_q[$];
    logic [8:0]  exp8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out32_extra: got %0h expected no beat at %0t", {cout, sum}, $time);
            end else begin
                check("out32", {31'd0, cout, sum}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out8_extra: got %0h expected no beat at %0t", {cout8, sum8}, $time);
            end else begin
                check("out8", {55'd0, cout8, sum8}, {55'd0, exp8_q.pop_front()});
            end
        end
    end

    // Output-valid run tracker used for the back-to-back stream.
    int cyc;
    int ov_cnt;
    int ov_first;
    int ov_last;
    bit ov_win;

    initial begin
        cyc      = 0;
        ov_cnt   = 0;
        ov_first = -1;
        ov_last  = -1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n && out_valid && ov_win) begin
            ov_cnt++;
            if (ov_first < 0) ov_first = cyc;
            ov_last = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat; waits (bounded) for in_ready. Call at posedge+#1.
    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic vc, input logic vs, input logic [32:0] ex);
        int guard;
        guard    = 0;
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
            @(posedge clk);
        end else begin
            @(posedge clk);
            exp_q.push_back(ex);
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe; measures cycles to out_valid.
    task automatic issue_and_time(input logic [31:0] va, input logic [31:0] vb,
                                  input logic vc, input logic vs,
                                  input logic [32:0] ex, input string name);
        int n;
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(ex);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, LAT32);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[12];

    // ---------------- main sequence ----------------
    initial begin
        n_vec = 0;
        n_bad = 0;
        ov_win = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1};
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1};
        vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};

        // Reset state
        step(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid8", out_valid8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // First beat latency: FFFFFFFF + 1
        issue_and_time(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub,
                       {vecs[0].cout, vecs[0].sum}, "lat_first");
        step(2);

        // Table vectors back-to-back
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, {vecs[i].cout, vecs[i].sum});
        end
        step(8);
        check("table_drained", exp_q.size(), 0);

        // Eight back-to-back beats a=i, b=i, cin=1 -> 2i+1
        ov_cnt = 0; ov_first = -1; ov_last = -1; ov_win = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i, i, 1'b1, 1'b0, {1'b0, 32'(2 * i + 1)});
        end
        step(8);
        ov_win = 1'b0;
        check("stream_count", ov_cnt, 8);
        check("stream_contig", ov_last - ov_first + 1, 8);
        check("stream_drained", exp_q.size(), 0);

        // Stream with a 3-cycle output stall in the middle
        fork
            begin : sender
                for (int i = 0; i < 8; i++) begin
                    send(100 + i, i, 1'b0, 1'b0, {1'b0, 32'(100 + 2 * i)});
                end
            end
            begin : staller
                int g;
                logic [32:0] held;
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    held = (exp_q.size() > 0) ? exp_q[0] : 33'h1_FFFF_FFFF;
                    check("stall_valid", out_valid, 1);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_hold", {cout, sum}, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        step(10);
        check("stall_drained", exp_q.size(), 0);

        // Asynchronous reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1 + i, 2, 1'b0, 1'b0, {1'b0, 32'(3 + i)});
        end
        step(2);
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_sum", sum, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_sum", sum, 0);
        check("async_rst_cout", cout, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(1);
        issue_and_time(vecs[2].a, vecs[2].b, vecs[2].cin, vecs[2].sub,
                       {vecs[2].cout, vecs[2].sum}, "lat_after_reset");
        step(3);
        check("reset_drained", exp_q.size(), 0);

`ifdef BK_SIGNED_OVF_EN
        issue_and_time(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 32'h8000_0000}, "lat_ovf_add");
        check("ovf_add", ovf, 1);
        step(2);
        issue_and_time(32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 32'h7FFF_FFFF}, "lat_ovf_sub");
        check("ovf_sub", ovf, 1);
        step(2);
        issue_and_time(32'h1, 32'h1, 1'b0, 1'b0, {1'b0, 32'h2}, "lat_ovf_none");
        check("ovf_none", ovf, 0);
        step(2);
`endif

        // 8-bit instance: latency, then a directed sweep against a+(b^m)+(cin^sub)
        a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        exp8_q.push_back(9'd7);
        #1;
        in_valid8 = 1'b0;
        begin
            int n;
            n = 1;
            while (!out_valid8 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("lat8", n, LAT8);
        end
        step(2);
        for (int ia = 0; ia < 256; ia += 17) begin
            for (int ib = 0; ib < 256; ib += 23) begin
                for (int m = 0; m < 4; m++) begin
                    logic [8:0] gold;
                    logic [7:0] beff;
                    logic       ceff;
                    a8   = 8'(ia);
                    b8   = 8'(ib);
                    cin8 = m[0];
                    sub8 = m[1];
                    beff = b8 ^ {8{sub8}};
                    ceff = cin8 ^ sub8;
                    gold = {1'b0, a8} + {1'b0, beff} + {8'd0, ceff};
                    in_valid8 = 1'b1;
                    @(posedge clk);
                    exp8_q.push_back(gold);
                    #1;
                end
            end
        end
        in_valid8 = 1'b0;
        step(5);
        check("sweep8_drained", exp8_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/brent_kung_pipe_adder.md
Name: brent_kung_pipe_adder

Overview:
Parametrised, pipelined Brent-Kung prefix adder/subtractor, successor to the fixed 32-bit combinational adder.
- Width is a power-of-two parameter; prefix levels are registered at a configurable interval; valid/ready handshakes on input and output.
- Adds carry-in and subtract mode.
- Sits between operand-issue logic and result writeback in the FPGA adder test harness.

Parameters:
WIDTH, 32, operand width; power of two, 4..128.
REG_EVERY, 3, prefix levels between internal pipeline registers; 0 means no internal registers.

Ports:
clk  in  1  single clock; all registers on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block accepts a beat this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in.
sub  in  1  1 selects A - B.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts the result.
sum  out  WIDTH  result bits.
cout  out  1  carry out of MSB.

Behaviour:
- Reset is asynchronous active-low: rst_n=0 immediately clears every stage valid bit, out_valid, sum and cout to 0; stage data registers also clear to 0.
- Reset mid-operation discards all in-flight beats. The first beat accepted after rst_n deasserts appears after the full latency.

Structure:
- Input register captures a, b_eff = b ^ {WIDTH{sub}}, c_eff = cin ^ sub.
- Level 0 (GP) per bit: g = a & b_eff, p = a ^ b_eff. Carry-in is folded as g0' = g0 | (p0 & c_eff).
- Brent-Kung network has L = 2*log2(WIDTH) - 1 levels: log2(WIDTH) up-sweep (black/gray cells), then log2(WIDTH) - 1 down-sweep (gray cells).
- An internal register follows level k*REG_EVERY for every k*REG_EVERY < L, carrying group g/p plus the level-0 p vector.
- Sum: sum[i] = p[i] ^ c[i], with c[0] = c_eff and c[i] = G[i-1:0]. cout = G[WIDTH-1:0]. Sum is computed from the last stage and captured in the output register.

Latency:
- LAT = ceil(L/REG_EVERY) + 1 cycles for REG_EVERY > 0, else 2.
- WIDTH=32, REG_EVERY=3 -> L=9, LAT=4.

Handshake:
- Global advance = !out_valid | out_ready; in_ready = advance.
- A beat is accepted when in_valid & in_ready.
- On advance, all stages shift one step and the valid bits propagate. Bubbles are overwritten; there is no bubble collapsing beyond this.
- With out_valid=1 and out_ready=0: every stage holds, and sum/cout/out_valid stay stable until accepted.
- Simultaneous output accept and input accept in the same cycle is legal and gives full throughput of 1 beat/cycle.

Arithmetic:
- Unsigned modulo 2^WIDTH.
- In sub mode, cout=1 means no borrow.

Optional Feature:
BK_SIGNED_OVF_EN
- Defined: adds output port ovf (1 bit), registered alongside sum.
- ovf = c[WIDTH-1] ^ cout, i.e. two's-complement signed overflow for both add and sub. Reset value 0; holds under stall like sum.
- Not defined: port absent, no extra logic.

Decomposition:
- Package bk_pkg holds:
  - function clog2-based level count bk_levels(WIDTH);
  - function bk_reg_after(level, REG_EVERY);
  - latency constant function bk_latency(WIDTH, REG_EVERY);
  - packed struct gp_t {g, p}.
- One sub-module, bk_prefix_level: parametrised by WIDTH and level index. It instantiates the black/gray cells of one up- or down-sweep level combinationally, and the top generates L copies.

Test Plan:
1. WIDTH=32, a=32'hFFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 -> after 4 cycles out_valid=1, sum=0, cout=1.
2. a=5, b=7, sub=1, cin=0 -> sum=32'hFFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
3. Stream 8 back-to-back beats (a=i, b=i, cin=1) with out_ready=1 -> 8 consecutive out_valid cycles, sum=2i+1. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, sum stable, no beat lost or duplicated.
4. Assert rst_n=0 asynchronously, mid-clock, with 3 beats in flight -> out_valid, sum and cout drop to 0 immediately. The next accepted beat emerges exactly LAT cycles later.
5. WIDTH=8, REG_EVERY=0, random 10k vectors vs golden a+(b^sub mask)+(cin^sub) -> LAT=2, zero mismatches.
6. BK_SIGNED_OVF_EN defined, a=32'h7FFF_FFFF, b=1, sub=0 -> ovf=1, sum=32'h8000_0000; a=32'h8000_0000, b=1, sub=1 -> ovf=1.
